// File: rtl/fsm_alu_seq.sv
// Multi-cycle load/compute/store sequencer: two operands in, compute, shift, two result beats out.
// Adds width/shift parameters, per-transaction mode, valid/ready streams, sticky overflow and done pulse.
module fsm_alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   // state   | meaning
   // S_IDLE  | waiting for start; done pulses here for one cycle after a transaction
   // S_LOAD1 | accepting first operand into reg_a
   // S_LOAD2 | accepting second operand into reg_b
   // S_OP1   | ADD / SUB / first half of ADDSUB / PASS
   // S_OP2   | SUB half of ADDSUB
   // S_SHIFT | left shift of reg_a, zero-filled
   // S_OUT1  | presenting reg_a
   // S_OUT2  | presenting reg_b
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD1, S_LOAD2, S_OP1, S_OP2, S_SHIFT, S_OUT1, S_OUT2
   } state_t;

   localparam logic [1:0] M_ADD    = 2'b00;
   localparam logic [1:0] M_SUB    = 2'b01;
   localparam logic [1:0] M_ADDSUB = 2'b10;
   localparam logic [1:0] M_PASS   = 2'b11;

   state_t             state, state_d;
   logic [WIDTH-1:0]   reg_a, reg_a_d;
   logic [WIDTH-1:0]   reg_b, reg_b_d;
   logic [1:0]         mode_q, mode_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] wide;

   // The extra top bit of diff is the borrow; the upper half of wide holds the shifted-out bits.
   assign sum  = {1'b0, reg_a} + {1'b0, reg_b};
   assign diff = {1'b0, reg_a} - {1'b0, reg_b};
   assign wide = {{WIDTH{1'b0}}, reg_a} << SHIFT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         reg_a  <= '0;
         reg_b  <= '0;
         mode_q <= 2'b00;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_d;
         reg_a  <= reg_a_d;
         reg_b  <= reg_b_d;
         mode_q <= mode_d;
         ovf_q  <= ovf_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      state_d   = state;
      reg_a_d   = reg_a;
      reg_b_d   = reg_b;
      mode_d    = mode_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      data_out  = '0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               ovf_d   = 1'b0;
               state_d = S_LOAD1;
            end
         end
         S_LOAD1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               reg_a_d = data_in;
               state_d = S_LOAD2;
            end
         end
         S_LOAD2: begin
            in_ready = 1'b1;
            if (in_valid) begin
               reg_b_d = data_in;
               state_d = S_OP1;
            end
         end
         S_OP1: begin
            state_d = S_SHIFT;
            case (mode_q)
               M_ADD: begin
                  reg_a_d = sum[WIDTH-1:0];
                  ovf_d   = ovf_q | sum[WIDTH];
               end
               M_SUB: begin
                  reg_a_d = diff[WIDTH-1:0];
                  ovf_d   = ovf_q | diff[WIDTH];
               end
               M_ADDSUB: begin
                  reg_a_d = sum[WIDTH-1:0];
                  ovf_d   = ovf_q | sum[WIDTH];
                  state_d = S_OP2;
               end
               M_PASS: begin
               end
               default: begin
               end
            endcase
         end
         S_OP2: begin
            reg_a_d = diff[WIDTH-1:0];
            ovf_d   = ovf_q | diff[WIDTH];
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            reg_a_d = wide[WIDTH-1:0];
            ovf_d   = ovf_q | (|wide[2*WIDTH-1:WIDTH]);
            state_d = S_OUT1;
         end
         S_OUT1: begin
            out_valid = 1'b1;
            data_out  = reg_a;
            if (out_ready) state_d = S_OUT2;
         end
         S_OUT2: begin
            out_valid = 1'b1;
            data_out  = reg_b;
            if (out_ready) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ovf  = ovf_q;
   assign done = done_q;

endmodule

// File: tb/tb_fsm_alu_seq.sv
// Testbench for fsm_alu_seq: directed vector table, multi-cycle corner sequences and
// randomized transactions against an arithmetic reference model (8-bit/shift-1 and 16-bit/shift-0).
module tb_fsm_alu_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start8 = 0, in_valid8 = 0, out_ready8 = 0;
   logic [1:0]  mode8 = 0;
   logic [7:0]  data_in8 = 0;
   logic        in_ready8, out_valid8, ovf8, busy8, done8;
   logic [7:0]  data_out8;

   logic        start16 = 0, in_valid16 = 0, out_ready16 = 0;
   logic [1:0]  mode16 = 0;
   logic [15:0] data_in16 = 0;
   logic        in_ready16, out_valid16, ovf16, busy16, done16;
   logic [15:0] data_out16;

   fsm_alu_seq #(.WIDTH(8), .SHIFT(1)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8),
      .in_valid(in_valid8), .in_ready(in_ready8), .data_in(data_in8),
      .out_valid(out_valid8), .out_ready(out_ready8), .data_out(data_out8),
      .ovf(ovf8), .busy(busy8), .done(done8)
   );

   fsm_alu_seq #(.WIDTH(16), .SHIFT(0)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .mode(mode16),
      .in_valid(in_valid16), .in_ready(in_ready16), .data_in(data_in16),
      .out_valid(out_valid16), .out_ready(out_ready16), .data_out(data_out16),
      .ovf(ovf16), .busy(busy16), .done(done16)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: 8-bit unsigned arithmetic, shift by one as a doubling.
   task automatic model8(input logic [1:0] m, input int a, input int b,
                         output int r, output bit ov);
      ov = 0;
      r  = a;
      if (m == 2'b00 || m == 2'b10) begin
         r = a + b;
         if (r > 255) begin ov = 1; r = r - 256; end
      end
      if (m == 2'b01 || m == 2'b10) begin
         if (r < b) begin ov = 1; r = r + 256 - b; end
         else r = r - b;
      end
      r = r * 2;
      if (r > 255) begin ov = 1; r = r - 256; end
   endtask

   // One transaction on dut8. Cycle numbers: start sampled at cycle 0.
   task automatic run8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input int in_st, input int out_st, input bit poke, input string tag,
                       output logic [7:0] o1, output logic [7:0] o2, output bit ov,
                       output int c1, output int cd);
      int cyc = 1, loads = 0, beats = 0, ist = in_st, ost = out_st;
      bit fin = 0, seen1 = 0, busy_bad = 0, zero_bad = 0, stable_bad = 0;
      o1 = 0; o2 = 0; ov = 0; c1 = -1; cd = -1;
      @(negedge clk);
      start8 = 1; mode8 = m; in_valid8 = 0; out_ready8 = 0;
      @(posedge clk);
      while (!fin && cyc < 60) begin
         @(negedge clk);
         start8 = 0;
         if (in_ready8) begin
            if (loads == 0 && ist > 0) begin
               in_valid8 = 0; data_in8 = 8'($urandom); ist--;
            end else begin
               if (poke && loads == 1) begin start8 = 1; mode8 = 2'b11; end
               in_valid8 = 1; data_in8 = (loads == 0) ? a : b; loads++;
            end
         end else in_valid8 = 0;
         if (out_valid8) begin
            if (beats == 0) begin
               if (!seen1) begin
                  c1 = cyc; o1 = data_out8; ov = ovf8; seen1 = 1;
               end else if (data_out8 !== o1 || ovf8 !== ov) stable_bad = 1;
               if (ost > 0) begin out_ready8 = 0; ost--; end
               else begin out_ready8 = 1; beats = 1; end
            end else begin
               o2 = data_out8; out_ready8 = 1; beats = 2;
            end
         end else begin
            out_ready8 = 0;
            if (data_out8 !== 8'h00) zero_bad = 1;
         end
         if (done8) begin cd = cyc; fin = 1; end
         else if (!busy8) busy_bad = 1;
         if (!fin) begin @(posedge clk); cyc++; end
      end
      in_valid8 = 0; out_ready8 = 0; start8 = 0;
      chk({tag, " finished"}, 32'(fin), 32'd1);
      chk({tag, " busy/zero/stable"}, {29'd0, busy_bad, zero_bad, stable_bad}, 32'd0);
      @(negedge clk);
      chk({tag, " done width"}, {30'd0, done8, busy8}, 32'd0);
   endtask

   typedef struct {
      logic [1:0] m;
      logic [7:0] a, b;
      int         ist, ost;
      bit         poke;
      logic [7:0] e1, e2;
      bit         eov;
      int         ec1, ecd;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [7:0] o1, o2;
      bit ov, eov;
      int c1, cd, r, bad;

      tbl[0] = '{2'b00, 8'h12, 8'h34, 0, 0, 1'b0, 8'h8C, 8'h34, 1'b0, 5, 7};
      tbl[1] = '{2'b01, 8'h10, 8'h20, 0, 0, 1'b0, 8'hE0, 8'h20, 1'b1, 5, 7};
      tbl[2] = '{2'b10, 8'hF0, 8'h20, 0, 0, 1'b0, 8'hE0, 8'h20, 1'b1, 6, 8};
      tbl[3] = '{2'b00, 8'h01, 8'h02, 3, 2, 1'b0, 8'h06, 8'h02, 1'b0, 8, 12};
      tbl[4] = '{2'b01, 8'h10, 8'h20, 0, 0, 1'b1, 8'hE0, 8'h20, 1'b1, 5, 7};
      tbl[5] = '{2'b11, 8'h81, 8'h05, 0, 0, 1'b0, 8'h02, 8'h05, 1'b1, 5, 7};
      tbl[6] = '{2'b00, 8'hFF, 8'h01, 0, 0, 1'b0, 8'h00, 8'h01, 1'b1, 5, 7};

      // Reset state, during and just after reset
      #12;
      chk("reset8 outputs", {19'd0, busy8, in_ready8, out_valid8, ovf8, done8, data_out8}, 32'd0);
      chk("reset16 outputs", {11'd0, busy16, in_ready16, out_valid16, ovf16, done16, data_out16}, 32'd0);
      @(negedge clk); rst = 0; #1;
      chk("release8 outputs", {19'd0, busy8, in_ready8, out_valid8, ovf8, done8, data_out8}, 32'd0);
      @(posedge clk); #1;
      chk("first cycle outputs", {19'd0, busy8, in_ready8, out_valid8, ovf8, done8, data_out8}, 32'd0);

      foreach (tbl[i]) begin
         string t;
         t = $sformatf("vec%0d", i);
         run8(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].ist, tbl[i].ost, tbl[i].poke, t, o1, o2, ov, c1, cd);
         chk({t, " out1"}, 32'(o1), 32'(tbl[i].e1));
         chk({t, " out2"}, 32'(o2), 32'(tbl[i].e2));
         chk({t, " ovf"}, 32'(ov), 32'(tbl[i].eov));
         chk({t, " out1 cycle"}, 32'(c1), 32'(tbl[i].ec1));
         chk({t, " done cycle"}, 32'(cd), 32'(tbl[i].ecd));
      end

      // Asynchronous reset while in OP1
      @(negedge clk); start8 = 1; mode8 = 2'b00;
      @(posedge clk); #1 start8 = 0; in_valid8 = 1; data_in8 = 8'h11;
      @(posedge clk); #1 data_in8 = 8'h22;
      @(posedge clk); #1 in_valid8 = 0;
      chk("op1 busy", 32'({busy8, in_ready8, out_valid8}), 32'b100);
      #2 rst = 1; #1;
      chk("async reset outputs", {19'd0, busy8, in_ready8, out_valid8, ovf8, done8, data_out8}, 32'd0);
      @(posedge clk); @(negedge clk); rst = 0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done8 || out_valid8 || busy8) bad = 1;
      end
      chk("no activity after reset", 32'(bad), 32'd0);
      run8(2'b00, 8'h12, 8'h34, 0, 0, 1'b0, "post-reset", o1, o2, ov, c1, cd);
      chk("post-reset out1", 32'(o1), 32'h8C);
      chk("post-reset out2", 32'(o2), 32'h34);
      chk("post-reset done cycle", 32'(cd), 32'd7);

      // Randomized transactions against the reference model
      for (int n = 0; n < 30; n++) begin
         logic [1:0] m;
         logic [7:0] a, b;
         int ist, ost;
         string t;
         m = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
         ist = int'($urandom_range(0, 2)); ost = int'($urandom_range(0, 2));
         t = $sformatf("rnd%0d m%0d %h %h", n, m, a, b);
         model8(m, int'(a), int'(b), r, eov);
         run8(m, a, b, ist, ost, 1'($urandom), t, o1, o2, ov, c1, cd);
         chk({t, " out1"}, 32'(o1), 32'(r));
         chk({t, " out2"}, 32'(o2), 32'(b));
         chk({t, " ovf"}, 32'(ov), 32'(eov));
         chk({t, " out1 cycle"}, 32'(c1), 32'(5 + (m == 2'b10 ? 1 : 0) + ist));
         chk({t, " done cycle"}, 32'(cd), 32'(5 + (m == 2'b10 ? 1 : 0) + ist + 2 + ost));
      end

      // 16-bit, no shift, PASS; start in the done cycle
      @(negedge clk);
      start16 = 1; mode16 = 2'b11; in_valid16 = 1; data_in16 = 16'hABCD; out_ready16 = 1;
      @(posedge clk); #1 start16 = 0;
      @(posedge clk); #1 data_in16 = 16'h1234;
      @(posedge clk); #1 in_valid16 = 0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("w16 out1", {14'd0, out_valid16, ovf16, data_out16}, {14'd0, 1'b1, 1'b0, 16'hABCD});
      @(posedge clk); #1;
      chk("w16 out2", {14'd0, out_valid16, ovf16, data_out16}, {14'd0, 1'b1, 1'b0, 16'h1234});
      @(posedge clk); #1;
      chk("w16 done", 32'({done16, busy16, out_valid16}), 32'b100);
      start16 = 1; mode16 = 2'b11;
      @(posedge clk); #1 start16 = 0;
      chk("w16 restart", 32'({busy16, done16, in_ready16}), 32'b101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_alu_seq.md
Name: fsm_alu_seq

Overview:
- Parametrised multi-cycle load/compute/store sequencer. Successor to the fixed 8-bit load-add-sub-shift-store FSM.
- Adds the following over the fixed block:
  - configurable datapath width and shift amount
  - per-transaction operation mode
  - valid/ready handshakes on the input and output streams
  - sticky overflow flag
  - busy indication and a single-cycle done pulse
- Sits between an operand stream source and a result consumer in the datapath control layer.

Parameters:
- WIDTH, 8: datapath width of operands, result and data ports (>=2).
- SHIFT, 1: left-shift amount applied in the SHIFT state (0..WIDTH-1; 0 means the value passes unchanged).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  transaction request; sampled only in IDLE
- mode  in  2  operation, captured with start: 00 ADD, 01 SUB, 10 ADDSUB, 11 PASS
- in_valid  in  1  data_in carries a valid operand
- in_ready  out  1  block accepts an operand this cycle
- data_in  in  WIDTH  operand stream
- out_valid  out  1  data_out carries a valid result beat
- out_ready  in  1  consumer accepts the beat
- data_out  out  WIDTH  result stream
- ovf  out  1  sticky carry/borrow/shift-out flag; valid while out_valid=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE; reg_a, reg_b, mode_q, ovf and done all clear to 0.
  - All outputs read 0 while rst=1 and in the first cycle after release.
  - Reset mid-transaction discards it: no done pulse, no further beats.
- States: IDLE, LOAD1, LOAD2, OP1, OP2, SHIFT, OUT1, OUT2.
- IDLE:
  - busy=0, in_ready=0, out_valid=0.
  - start=1 captures mode into mode_q, clears ovf and moves to LOAD1.
  - start is ignored in all other states.
- LOAD1 / LOAD2:
  - in_ready=1.
  - A handshake (in_valid & in_ready) writes reg_a (LOAD1) or reg_b (LOAD2) and advances.
  - With in_valid=0 the state holds and the registers are unchanged.
- OP1:
  - ADD: reg_a <= reg_a + reg_b (mod 2^WIDTH); ovf |= carry-out.
  - SUB: reg_a <= reg_a - reg_b (mod 2^WIDTH); ovf |= borrow (reg_a < reg_b unsigned).
  - ADDSUB: performs the ADD, then goes to OP2.
  - PASS: no change.
  - All modes except ADDSUB go to SHIFT.
- OP2 (ADDSUB only): performs the SUB on the updated reg_a, with the borrow rule above, then goes to SHIFT.
- SHIFT:
  - reg_a <= reg_a << SHIFT, zero-filled.
  - ovf |= OR of the SHIFT bits shifted out.
  - Unconditionally goes to OUT1.
- OUT1:
  - out_valid=1, data_out=reg_a.
  - On out_ready=1, moves to OUT2; otherwise holds with data_out and ovf stable.
- OUT2:
  - out_valid=1, data_out=reg_b.
  - On out_ready=1, moves to IDLE and done is set for exactly the next cycle.
- Outside OUT1/OUT2, data_out=0.
- done:
  - Registered; high only in the first IDLE cycle after the OUT2 handshake.
  - A start in that same cycle is accepted.
- Latency with in_valid=1 and out_ready=1 throughout (start sampled at cycle 0):
  - ADD/SUB/PASS: OUT1 at cycle 5, OUT2 at cycle 6, done at cycle 7.
  - ADDSUB: each of these is one cycle later.
  - Every stall cycle adds one cycle.
- All arithmetic is unsigned WIDTH-bit with wrap-around. Carry, borrow and shift-out bits are kept only through ovf.

Test Plan:
- WIDTH=8, SHIFT=1, ADD, operands 0x12, 0x34, no stalls:
  - OUT1=0x8C (cycle 5), OUT2=0x34 (cycle 6), ovf=0, done=1 at cycle 7 only.
- SUB, operands 0x10, 0x20:
  - subtraction gives 0xF0 with borrow; shift gives 0xE0 with shift-out 1.
  - OUT1=0xE0, OUT2=0x20, ovf=1.
- ADDSUB, operands 0xF0, 0x20:
  - add gives 0x10 with carry; sub gives 0xF0 with borrow; shift gives 0xE0.
  - OUT1=0xE0 (cycle 6), OUT2=0x20, ovf=1, done at cycle 8.
- Backpressure on ADD, operands 0x01, 0x02:
  - stimulus: in_valid low for 3 cycles in LOAD1; out_ready low for 2 cycles in OUT1.
  - response: in_ready stays high and the registers hold during the input stall.
  - data_out=0x06 and out_valid stay stable through the output stall.
  - done appears at cycle 12.
- Reset: rst asserted asynchronously while in OP1:
  - outputs go to 0 immediately and no done pulse occurs.
  - A new start after release completes normally.
  - A start pulsed during LOAD2 changes neither mode nor flow.
- WIDTH=16, SHIFT=0, PASS, operands 0xABCD, 0x1234:
  - OUT1=0xABCD, OUT2=0x1234, ovf=0.
  - Start asserted in the done cycle launches the next transaction with busy=1 the following cycle.
